led_fade_pwm: RTL and testbench



---
 rtl/led_fade_pwm.sv | 187 ++++++++++++++++++
 tb/tb_led_fade_pwm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: multi-channel LED dimmer. Each level ramps linearly toward a target and drives a
// glitch-free PWM output. Define FADE_GAMMA_EN to map level to duty through an approximate gamma-2 curve.
module led_fade_pwm #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [CHANNELS*PWM_BITS-1:0] target,
  input  logic [PWM_BITS-1:0]          step,
  input  logic                         load,
  output logic [CHANNELS*PWM_BITS-1:0] level,
  output logic [CHANNELS-1:0]          pwm_out,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]    DIV_LOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = LVL_MAX - PWM_BITS'(1);
`ifdef FADE_GAMMA_EN
  localparam int unsigned SQ_W = 2 * PWM_BITS;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [PWM_BITS-1:0] lvl_q       [CHANNELS];
  logic [PWM_BITS-1:0] lvl_d       [CHANNELS];
  logic [PWM_BITS-1:0] tgt_q       [CHANNELS];
  logic [PWM_BITS-1:0] tgt_d       [CHANNELS];
  logic [PWM_BITS-1:0] tgt_in      [CHANNELS];
  logic [PWM_BITS-1:0] duty_shadow [CHANNELS];
  logic [PWM_BITS-1:0] cmp         [CHANNELS];

  logic [PWM_BITS-1:0] step_q;
  logic [PWM_BITS-1:0] step_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_q;
  logic                tick;
  logic                cnt_wrap;
  logic                all_eq;
  logic                done_d;

  // Move cur toward tgt by at most stp; the extra bit keeps the gap arithmetic free of wrap-around.
  function automatic logic [PWM_BITS-1:0] step_toward(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt,
    input logic [PWM_BITS-1:0] stp
  );
    logic [PWM_BITS:0] c;
    logic [PWM_BITS:0] t;
    logic [PWM_BITS:0] s;
    logic [PWM_BITS:0] gap;
    logic [PWM_BITS:0] res;
    c   = {1'b0, cur};
    t   = {1'b0, tgt};
    s   = {1'b0, stp};
    gap = '0;
    res = c;
    if (c < t) begin
      gap = t - c;
      res = c + ((s < gap) ? s : gap);
    end else if (c > t) begin
      gap = c - t;
      res = c - ((s < gap) ? s : gap);
    end
    return PWM_BITS'(res);
  endfunction

  // Level to PWM compare value.
  function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] lvl);
`ifdef FADE_GAMMA_EN
    logic [SQ_W-1:0] sq;
    sq = SQ_W'(lvl) * SQ_W'(lvl);
    return (lvl == LVL_MAX) ? LVL_MAX : PWM_BITS'(sq >> PWM_BITS);
`else
    return lvl;
`endif
  endfunction

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_pack
    assign tgt_in[g]                          = target[g*PWM_BITS +: PWM_BITS];
    assign level[g*PWM_BITS +: PWM_BITS]      = lvl_q[g];
  end

  assign tick     = (div_q == '0);
  assign cnt_wrap = (pwm_cnt == CNT_LAST);

  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      cmp[i] = duty_of(lvl_q[i]);
    end
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, fade stepping and completion
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    step_d  = step_q;
    all_eq  = 1'b1;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      lvl_d[i] = lvl_q[i];
      tgt_d[i] = tgt_q[i];
      if (lvl_q[i] != tgt_q[i]) begin
        all_eq = 1'b0;
      end
    end

    if (load) begin
      // Load wins over a coincident tick: latch only, no step this cycle.
      state_d = FADE;
      step_d  = (step == '0) ? PWM_BITS'(1) : step;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        tgt_d[i] = tgt_in[i];
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FADE: begin
          if (all_eq) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (tick) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
              lvl_d[i] = step_toward(lvl_q[i], tgt_q[i], step_q);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath, divider, PWM and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        lvl_q[i]       <= '0;
        tgt_q[i]       <= '0;
        duty_shadow[i] <= '0;
      end
      step_q  <= PWM_BITS'(1);
      pwm_cnt <= '0;
      pwm_out <= '0;
      div_q   <= DIV_LOAD;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        lvl_q[i]   <= lvl_d[i];
        tgt_q[i]   <= tgt_d[i];
        pwm_out[i] <= (pwm_cnt < duty_shadow[i]);
        // Shadow only updates at the period boundary so a period never glitches.
        if (cnt_wrap) begin
          duty_shadow[i] <= cmp[i];
        end
      end
      step_q  <= step_d;
      pwm_cnt <= cnt_wrap ? '0 : pwm_cnt + PWM_BITS'(1);
      div_q   <= (load || tick) ? DIV_LOAD : div_q - DIV_W'(1);
      busy    <= (state_d == FADE);
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: table vectors, directed corner sequences and random stimulus against an
// arithmetic reference model of the dimmer (CHANNELS=3, PWM_BITS=4, TICK_DIV=4).
module tb_led_fade_pwm;

  localparam int unsigned CH   = 3;
  localparam int unsigned PB   = 4;
  localparam int unsigned TD   = 4;
  localparam int          LMAX = (1 << PB) - 1;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic              load;
  logic [CH*PB-1:0]  target;
  logic [PB-1:0]     step;
  logic [CH*PB-1:0]  level;
  logic [CH-1:0]     pwm_out;
  logic              busy;
  logic              done;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int        m_lvl    [CH];
  int        m_tgt    [CH];
  int        m_shadow [CH];
  int        m_step;
  int        m_age;
  int        m_pos;
  bit        m_fade;
  bit        m_done;
  bit [CH-1:0] m_pwm;

  typedef struct {
    logic             rst;
    logic             ld;
    logic [CH*PB-1:0] tgt;
    logic [PB-1:0]    stp;
    int               e_l0;
    logic             e_busy;
    logic             e_done;
  } vec_t;

  vec_t tbl [16];

  led_fade_pwm #(
    .CHANNELS(CH),
    .PWM_BITS(PB),
    .TICK_DIV(TD)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .target  (target),
    .step    (step),
    .load    (load),
    .level   (level),
    .pwm_out (pwm_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int cmp_val(input int l);
`ifdef FADE_GAMMA_EN
    return (l == LMAX) ? LMAX : ((l * l) >> PB);
`else
    return l;
`endif
  endfunction

  // Advance the model by one rising edge using the inputs presented before that edge.
  task automatic model_edge();
    bit tick;
    bit eq;
    int d;
    if (!reset) begin
      for (int i = 0; i < int'(CH); i++) begin
        m_lvl[i] = 0; m_tgt[i] = 0; m_shadow[i] = 0;
      end
      m_step = 1; m_age = 0; m_pos = 0; m_fade = 0; m_done = 0; m_pwm = '0;
      return;
    end
    for (int i = 0; i < int'(CH); i++) m_pwm[i] = (m_pos < m_shadow[i]);
    if (m_pos == LMAX - 1)
      for (int i = 0; i < int'(CH); i++) m_shadow[i] = cmp_val(m_lvl[i]);
    m_pos = (m_pos + 1) % LMAX;
    tick  = ((m_age % int'(TD)) == int'(TD) - 1);
    eq    = 1'b1;
    for (int i = 0; i < int'(CH); i++) if (m_lvl[i] != m_tgt[i]) eq = 1'b0;
    m_done = 1'b0;
    if (load) begin
      for (int i = 0; i < int'(CH); i++) m_tgt[i] = int'(target[i*PB +: PB]);
      m_step = (step == '0) ? 1 : int'(step);
      m_fade = 1'b1;
      m_age  = 0;
    end else begin
      if (m_fade && eq) begin
        m_fade = 1'b0;
        m_done = 1'b1;
      end else if (m_fade && tick) begin
        for (int i = 0; i < int'(CH); i++) begin
          d = m_tgt[i] - m_lvl[i];
          if (d > 0)      m_lvl[i] += (d < m_step) ? d : m_step;
          else if (d < 0) m_lvl[i] -= (-d < m_step) ? -d : m_step;
        end
      end
      m_age++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: update the model, then compare every output 1ns after the edge.
  task automatic tick_clk();
    logic [CH*PB-1:0] el;
    @(posedge CLOCK_50);
    model_edge();
    #1;
    for (int i = 0; i < int'(CH); i++) el[i*PB +: PB] = PB'(m_lvl[i]);
    check("model", 32'({level, pwm_out, busy, done}), 32'({el, m_pwm, m_fade, m_done}));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic do_load(input logic [CH*PB-1:0] t, input logic [PB-1:0] s);
    target = t; step = s; load = 1'b1;
    tick_clk();
    load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick_clk();
    reset = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick_clk();
      n++;
    end
    check(name, 32'(done === 1'b1), 32'd1);
  endtask

  task automatic count_duty(input string name, input int e0, input int e1, input int e2);
    int c [CH];
    for (int i = 0; i < int'(CH); i++) c[i] = 0;
    for (int k = 0; k < LMAX; k++) begin
      tick_clk();
      for (int i = 0; i < int'(CH); i++) c[i] += int'(pwm_out[i]);
    end
    check({name, "_ch0"}, 32'(c[0]), 32'(e0));
    check({name, "_ch1"}, 32'(c[1]), 32'(e1));
    check({name, "_ch2"}, 32'(c[2]), 32'(e2));
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; target = '0; step = '0;

    // Ramp-up table: row 0 is reset with a concurrent load, row 1 is the load edge k.
    tbl[0] = '{rst: 1'b0, ld: 1'b1, tgt: 12'd12, stp: 4'd4, e_l0: 0, e_busy: 1'b0, e_done: 1'b0};
    tbl[1] = '{rst: 1'b1, ld: 1'b1, tgt: 12'd12, stp: 4'd4, e_l0: 0, e_busy: 1'b1, e_done: 1'b0};
    for (int j = 2; j < 16; j++) begin
      tbl[j].rst    = 1'b1;
      tbl[j].ld     = 1'b0;
      tbl[j].tgt    = 12'd12;
      tbl[j].stp    = 4'd4;
      tbl[j].e_l0   = ((j - 1) >= 12) ? 12 : ((j - 1) / 4) * 4;
      tbl[j].e_busy = ((j - 1) <= 12);
      tbl[j].e_done = ((j - 1) == 13);
    end

    for (int j = 0; j < 16; j++) begin
      reset = tbl[j].rst; load = tbl[j].ld; target = tbl[j].tgt; step = tbl[j].stp;
      tick_clk();
      check($sformatf("ramp_l0_%0d", j), 32'(level[PB-1:0]), 32'(tbl[j].e_l0));
      check($sformatf("ramp_busy_%0d", j), 32'(busy), 32'(tbl[j].e_busy));
      check($sformatf("ramp_done_%0d", j), 32'(done), 32'(tbl[j].e_done));
    end
    load = 1'b0; reset = 1'b1;
    check("reset_pwm_idle", 32'(pwm_out), 32'd0);

    // Saturating up-ramp then down-ramp
    do_reset();
    do_load(12'd10, 4'd4);
    run(4);  check("sat_up_4", 32'(level[PB-1:0]), 32'd4);
    run(4);  check("sat_up_8", 32'(level[PB-1:0]), 32'd8);
    run(4);  check("sat_up_10", 32'(level[PB-1:0]), 32'd10);
    wait_done("sat_up_done", 20);
    do_load(12'd1, 4'd3);
    run(4);  check("down_7", 32'(level[PB-1:0]), 32'd7);
    run(4);  check("down_4", 32'(level[PB-1:0]), 32'd4);
    run(4);  check("down_1", 32'(level[PB-1:0]), 32'd1);
    run(8);  check("down_floor", 32'(level[PB-1:0]), 32'd1);

    // Retarget on the tick cycle: the load wins and no step lands
    do_reset();
    do_load(12'd12, 4'd4);
    run(8);  check("rt_at8", 32'(level[PB-1:0]), 32'd8);
    run(3);
    do_load(12'd2, 4'd4);
    check("rt_collide", 32'(level[PB-1:0]), 32'd8);
    run(3);  check("rt_hold", 32'(level[PB-1:0]), 32'd8);
    run(1);  check("rt_4", 32'(level[PB-1:0]), 32'd4);
    run(4);  check("rt_2", 32'(level[PB-1:0]), 32'd2);
    check("rt_busy", 32'({busy, done}), 32'b10);
    run(1);  check("rt_done", 32'({busy, done}), 32'b01);

    // Null fade: target equals current levels
    do_load(12'h002, 4'd1);
    check("null_busy", 32'({busy, done}), 32'b10);
    tick_clk();
    check("null_done", 32'({busy, done}), 32'b01);

    // Duty at levels 0 / 15 / 5
    do_load({4'd5, 4'd15, 4'd0}, 4'd15);
    wait_done("duty_done", 40);
    run(16);
`ifdef FADE_GAMMA_EN
    count_duty("duty", 0, 15, 1);
`else
    count_duty("duty", 0, 15, 5);
`endif

    // Level 8 duty (gamma or linear)
    do_load({4'd8, 4'd15, 4'd0}, 4'd15);
    wait_done("l8_done", 40);
    run(16);
`ifdef FADE_GAMMA_EN
    count_duty("l8", 0, 15, 4);
`else
    count_duty("l8", 0, 15, 8);
`endif

    // Reset mid-fade with a concurrent load
    do_load({4'd15, 4'd0, 4'd15}, 4'd1);
    run(6);
    reset = 1'b0; load = 1'b1; target = {4'd9, 4'd9, 4'd9}; step = 4'd2;
    tick_clk();
    reset = 1'b1; load = 1'b0;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_out", 32'({pwm_out, busy, done}), 32'd0);
    run(12);
    check("mid_rst_after", 32'({level, busy}), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset  = ($urandom_range(0, 499) != 0);
      load   = ($urandom_range(0, 24) == 0);
      target = CH*PB'($urandom);
      step   = ($urandom_range(0, 3) == 0) ? PB'($urandom) : PB'($urandom_range(0, 4));
      tick_clk();
    end
    reset = 1'b1; load = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
